// File: rtl/ahb_slv_mem.sv
// AHB-Lite slave memory with configurable width, depth and wait states, byte-lane writes and a two-cycle ERROR response.
// Optional macro AHB_SLV_PROT_CHK_EN: user-mode (hprot[1]=0) accesses to the upper half of memory are rejected.
module ahb_slv_mem #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           MEM_DEPTH   = 256,
    parameter int unsigned           WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0
) (
    input  logic                  clk,
    input  logic                  hreset_n,
    input  logic                  ahb_slv_hsel,
    input  logic [ADDR_WIDTH-1:0] ahb_slv_haddr,
    input  logic [1:0]            ahb_slv_htrans,
    input  logic                  ahb_slv_hwrite,
    input  logic [2:0]            ahb_slv_hsize,
    input  logic [2:0]            ahb_slv_hburst,
    input  logic [3:0]            ahb_slv_hprot,
    input  logic [DATA_WIDTH-1:0] ahb_slv_hwdata,
    input  logic                  ahb_slv_hready,
    output logic [DATA_WIDTH-1:0] slv_ahb_hrdata,
    output logic                  slv_ahb_hready,
    output logic [1:0]            slv_ahb_hresp
);
    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned LANE_W = $clog2(NBYTES);
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * longint'(NBYTES);
    localparam logic [2:0]  MAX_SIZE  = 3'(LANE_W);
    localparam logic [3:0]  WAIT_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
`ifdef AHB_SLV_PROT_CHK_EN
    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(MEM_DEPTH / 2);
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
    state_t                state_r, state_s;
    logic [3:0]            cnt_r, cnt_s;
    logic [IDX_W-1:0]      idx_r, idx_s, rd_idx_s;
    logic [LANE_W-1:0]     lane_r;
    logic [2:0]            size_r;
    logic                  write_r, err_r;
    logic                  hready_r;
    logic [1:0]            hresp_r;
    logic [DATA_WIDTH-1:0] hrdata_r, mem_word_s, rd_word_s;
    logic [ADDR_WIDTH-1:0] offset_s;
    logic                  accept_s, misalign_s, err_s, wr_en_s;
    logic [NBYTES-1:0]     be_s;
    logic                  unused_s;

    assign unused_s = ^{ahb_slv_hburst, ahb_slv_hprot};

    // Address-phase decode: accept qualifier, word index and legality of the incoming transfer
    always_comb begin
        offset_s   = ahb_slv_haddr - BASE_ADDR;
        idx_s      = offset_s[LANE_W +: IDX_W];
        accept_s   = ahb_slv_hsel & ahb_slv_hready & ahb_slv_htrans[1] & hready_r;
        misalign_s = 1'b0;
        case (ahb_slv_hsize)
            3'd0:    misalign_s = 1'b0;
            3'd1:    misalign_s = ahb_slv_haddr[0];
            3'd2:    misalign_s = |ahb_slv_haddr[1:0];
            3'd3:    misalign_s = |ahb_slv_haddr[2:0];
            default: misalign_s = 1'b1;
        endcase
        err_s = (ahb_slv_haddr < BASE_ADDR)
              | (longint'(offset_s) >= MEM_BYTES)
              | (ahb_slv_hsize > MAX_SIZE)
              | misalign_s;
`ifdef AHB_SLV_PROT_CHK_EN
        err_s = err_s | (~ahb_slv_hprot[1] & (idx_s >= HALF_IDX));
`endif
    end

    // Byte-lane enables of the write committing at the end of the DATA cycle
    always_comb begin
        wr_en_s = (state_r == ST_DATA) & write_r & ~err_r;
        for (int b = 0; b < NBYTES; b++) begin
            be_s[b] = wr_en_s && (b >= int'(lane_r)) && (b < int'(lane_r) + (1 << size_r));
        end
    end

    // Next-state logic; a finishing data phase may accept the next address phase directly
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rd_idx_s = idx_r;
        case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    rd_idx_s = idx_s;
                    cnt_s    = 4'd0;
                    if (err_s) begin
                        state_s = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == WAIT_LAST) begin
                    state_s = ST_DATA;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_ERR1: state_s = ST_ERR2;
            default: state_s = ST_IDLE;
        endcase
    end

    // Read word with bypass of a write to the same word committing on this edge
    always_comb begin
        mem_word_s = mem_r[rd_idx_s];
        rd_word_s  = mem_word_s;
        for (int b = 0; b < NBYTES; b++) begin
            rd_word_s[b*8 +: 8] = (be_s[b] && (idx_r == rd_idx_s)) ? ahb_slv_hwdata[b*8 +: 8]
                                                                    : mem_word_s[b*8 +: 8];
        end
    end

    // Control state, captured address phase and registered bus outputs
    always_ff @(posedge clk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            idx_r    <= {IDX_W{1'b0}};
            lane_r   <= {LANE_W{1'b0}};
            size_r   <= 3'd0;
            write_r  <= 1'b0;
            err_r    <= 1'b0;
            hready_r <= 1'b1;
            hresp_r  <= 2'b00;
            hrdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                idx_r   <= idx_s;
                lane_r  <= ahb_slv_haddr[LANE_W-1:0];
                size_r  <= ahb_slv_hsize;
                write_r <= ahb_slv_hwrite;
                err_r   <= err_s;
            end
            hready_r <= (state_s == ST_IDLE) | (state_s == ST_DATA) | (state_s == ST_ERR2);
            hresp_r  <= ((state_s == ST_ERR1) | (state_s == ST_ERR2)) ? 2'b01 : 2'b00;
            hrdata_r <= (state_s == ST_DATA) ? rd_word_s : {DATA_WIDTH{1'b0}};
        end
    end

    // Storage array; contents intentionally survive reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (be_s[b]) begin
                mem_r[idx_r][b*8 +: 8] <= ahb_slv_hwdata[b*8 +: 8];
            end
        end
    end

    assign slv_ahb_hready = hready_r;
    assign slv_ahb_hresp  = hresp_r;
    assign slv_ahb_hrdata = hrdata_r;
endmodule

// File: tb/tb_ahb_slv_mem.sv
// Bench for ahb_slv_mem: a zero-wait instance at base 0 and a three-wait instance at base 0x1000,
// driven by a pipelined AHB master and checked against a byte-array memory model.
module tb_ahb_slv_mem;
    localparam int          MEM_DEPTH = 256;
    localparam logic [31:0] BASE0     = 32'h0000_0000;
    localparam logic [31:0] BASE1     = 32'h0000_1000;
`ifdef AHB_SLV_PROT_CHK_EN
    localparam bit PROT_CHK = 1'b1;
`else
    localparam bit PROT_CHK = 1'b0;
`endif

    typedef struct {
        int          d;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  prot;
    } item_t;

    logic        clk = 1'b0;
    logic        hreset_n;
    logic        hsel0, hsel1, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] hrdata0, hrdata1;
    logic        hready0, hready1;
    logic [1:0]  hresp0, hresp1;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem_m [2][MEM_DEPTH*4];
    item_t       q[$];
    logic [31:0] last_rd;
    logic [31:0] wd4;

    always #5 clk = ~clk;

    ahb_slv_mem #(.WAIT_STATES(0), .BASE_ADDR(BASE0)) u_dut0 (
        .clk(clk), .hreset_n(hreset_n), .ahb_slv_hsel(hsel0), .ahb_slv_haddr(haddr),
        .ahb_slv_htrans(htrans), .ahb_slv_hwrite(hwrite), .ahb_slv_hsize(hsize),
        .ahb_slv_hburst(hburst), .ahb_slv_hprot(hprot), .ahb_slv_hwdata(hwdata),
        .ahb_slv_hready(hready0), .slv_ahb_hrdata(hrdata0), .slv_ahb_hready(hready0),
        .slv_ahb_hresp(hresp0));

    ahb_slv_mem #(.WAIT_STATES(3), .BASE_ADDR(BASE1)) u_dut1 (
        .clk(clk), .hreset_n(hreset_n), .ahb_slv_hsel(hsel1), .ahb_slv_haddr(haddr),
        .ahb_slv_htrans(htrans), .ahb_slv_hwrite(hwrite), .ahb_slv_hsize(hsize),
        .ahb_slv_hburst(hburst), .ahb_slv_hprot(hprot), .ahb_slv_hwdata(hwdata),
        .ahb_slv_hready(hready1), .slv_ahb_hrdata(hrdata1), .slv_ahb_hready(hready1),
        .slv_ahb_hresp(hresp1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int waits_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? hready0 : hready1;
    endfunction

    function automatic logic [31:0] get_resp(input int d);
        return {30'd0, (d == 0) ? hresp0 : hresp1};
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? hrdata0 : hrdata1;
    endfunction

    function automatic bit legal(input int d, input logic [31:0] addr, input logic [2:0] size,
                                 input logic [3:0] prot);
        longint off;
        off = longint'({32'h0, addr}) - longint'({32'h0, base_of(d)});
        if (off < 0 || off >= longint'(MEM_DEPTH * 4)) return 1'b0;
        if (size > 3'd2) return 1'b0;
        if ((addr % (32'd1 << size)) != 32'd0) return 1'b0;
        if (PROT_CHK && !prot[1] && (off / 4) >= longint'(MEM_DEPTH / 2)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_word(input int d, input logic [31:0] addr);
        int w;
        w = int'((addr - base_of(d)) >> 2);
        return {mem_m[d][4*w+3], mem_m[d][4*w+2], mem_m[d][4*w+1], mem_m[d][4*w]};
    endfunction

    function automatic void model_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                                        input logic [31:0] wdata);
        int off;
        off = int'(addr - base_of(d));
        for (int k = 0; k < (1 << size); k++) begin
            mem_m[d][off + k] = wdata[((off + k) % 4) * 8 +: 8];
        end
    endfunction

    function automatic item_t mk(input int d, input logic [1:0] trans, input logic [31:0] addr,
                                 input logic write, input logic [2:0] size, input logic [31:0] wdata,
                                 input logic [3:0] prot);
        item_t it;
        it.d = d; it.trans = trans; it.addr = addr; it.write = write;
        it.size = size; it.wdata = wdata; it.prot = prot;
        return it;
    endfunction

    function automatic item_t rnd_item(input int d);
        item_t       it;
        int          r;
        logic [31:0] off;
        it.d = d;
        r = $urandom_range(0, 9);
        it.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
        it.size = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 15) == 0) it.size = 3'd3;
        off = 32'($urandom_range(0, MEM_DEPTH - 1)) * 32'd4 + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) != 0) off = off & ~((32'd1 << it.size) - 32'd1);
        r = $urandom_range(0, 15);
        if (r == 0) off = 32'(MEM_DEPTH * 4) + 32'($urandom_range(0, 255));
        if (r == 1) off = 32'hFFFF_FFF0;
        it.addr  = base_of(d) + off;
        it.write = 1'($urandom_range(0, 1));
        it.wdata = $urandom;
        it.prot  = 4'($urandom_range(0, 15));
        return it;
    endfunction

    task automatic drive_addr(input item_t it);
        hsel0  = (it.d == 0);
        hsel1  = (it.d == 1);
        haddr  = it.addr;
        htrans = it.trans;
        hwrite = it.write;
        hsize  = it.size;
        hprot  = it.prot;
        hburst = 3'($urandom_range(0, 7));
    endtask

    task automatic drive_idle();
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hsize  = 3'd2;
        hprot  = 4'b0011;
        hburst = 3'd0;
    endtask

    // Pipelined master: address phase of item i overlaps the data phase of item i-1.
    task automatic run();
        item_t p;
        int    n, d, ew, waits;
        bit    ok, xf;
        n = q.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive_addr(q[i]);
            else drive_idle();
            if (i > 0) begin
                p      = q[i-1];
                d      = p.d;
                hwdata = p.wdata;
                xf     = p.trans[1];
                ok     = legal(d, p.addr, p.size, p.prot);
                ew     = !xf ? 0 : (ok ? waits_of(d) : 1);
                waits  = 0;
                forever begin
                    @(negedge clk);
                    if (get_ready(d) === 1'b1 || waits > ew) break;
                    chk("wait_resp", get_resp(d), (xf && !ok) ? 32'd1 : 32'd0);
                    chk("wait_rdata", get_rdata(d), 32'd0);
                    waits++;
                    @(posedge clk); #1;
                end
                chk("wait_count", 32'(waits), 32'(ew));
                chk("resp", get_resp(d), (xf && !ok) ? 32'd1 : 32'd0);
                if (!xf || !ok) begin
                    chk("rdata_zero", get_rdata(d), 32'd0);
                end else if (!p.write) begin
                    last_rd = get_rdata(d);
                    chk("rdata", last_rd, model_word(d, p.addr));
                end else begin
                    model_write(d, p.addr, p.size, p.wdata);
                end
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    initial begin
        hreset_n = 1'b0;
        hwdata   = 32'h0;
        last_rd  = 32'h0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hready0", {31'd0, hready0}, 32'd1);
        chk("rst_hresp0", {30'd0, hresp0}, 32'd0);
        chk("rst_hrdata0", hrdata0, 32'd0);
        chk("rst_hready1", {31'd0, hready1}, 32'd1);
        chk("rst_hresp1", {30'd0, hresp1}, 32'd0);
        chk("rst_hrdata1", hrdata1, 32'd0);
        @(negedge clk);
        hreset_n = 1'b1;
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < MEM_DEPTH; w++)
                q.push_back(mk(d, 2'b10, base_of(d) + 32'(w * 4), 1'b1, 3'd2, $urandom, 4'b0011));
            run();
        end

        q.push_back(mk(0, 2'b10, 32'h4, 1'b1, 3'd2, 32'h1234_5678, 4'b0011));
        q.push_back(mk(0, 2'b10, 32'h4, 1'b0, 3'd2, 32'h0, 4'b0011));
        run();
        chk("rb_word", last_rd, 32'h1234_5678);

        q.push_back(mk(1, 2'b10, BASE1 + 32'h8, 1'b0, 3'd2, 32'h0, 4'b0011));
        q.push_back(mk(1, 2'b00, BASE1, 1'b0, 3'd2, 32'h0, 4'b0011));
        for (int k = 0; k < 3; k++)
            q.push_back(mk(1, 2'b10, BASE1 + 32'(k * 4), 1'b0, 3'd2, 32'h0, 4'b0011));
        run();

        q.push_back(mk(0, 2'b10, 32'h4, 1'b1, 3'd2, 32'hFFFF_FFFF, 4'b0011));
        q.push_back(mk(0, 2'b10, 32'h6, 1'b1, 3'd0, 32'h12AB_3456, 4'b0011));
        q.push_back(mk(0, 2'b10, 32'h4, 1'b0, 3'd2, 32'h0, 4'b0011));
        run();
        chk("byte_lane_rb", last_rd, 32'hFFAB_FFFF);
        q.push_back(mk(0, 2'b10, 32'h1, 1'b1, 3'd1, 32'h5555_5555, 4'b0011));
        q.push_back(mk(0, 2'b10, 32'h0, 1'b0, 3'd2, 32'h0, 4'b0011));
        q.push_back(mk(0, 2'b10, 32'h8, 1'b0, 3'd3, 32'h0, 4'b0011));
        q.push_back(mk(0, 2'b10, 32'hA, 1'b1, 3'd1, 32'hBEEF_0000, 4'b0011));
        q.push_back(mk(0, 2'b10, 32'h8, 1'b0, 3'd2, 32'h0, 4'b0011));
        run();

        q.push_back(mk(0, 2'b10, 32'(MEM_DEPTH * 4), 1'b0, 3'd2, 32'h0, 4'b0011));
        q.push_back(mk(0, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0, 4'b0011));
        run();
        q.push_back(mk(1, 2'b10, BASE1 - 32'h4, 1'b1, 3'd2, 32'h0, 4'b0011));
        q.push_back(mk(1, 2'b10, BASE1 + 32'(MEM_DEPTH * 4), 1'b0, 3'd2, 32'h0, 4'b0011));
        q.push_back(mk(1, 2'b10, BASE1 + 32'h10, 1'b0, 3'd2, 32'h0, 4'b0011));
        run();

        for (int d = 0; d < 2; d++) begin
            wd4 = $urandom;
            q.push_back(mk(d, 2'b10, base_of(d) + 32'h40, 1'b1, 3'd2, $urandom, 4'b0011));
            q.push_back(mk(d, 2'b11, base_of(d) + 32'h44, 1'b1, 3'd2, $urandom, 4'b0011));
            q.push_back(mk(d, 2'b01, base_of(d) + 32'h48, 1'b1, 3'd2, $urandom, 4'b0011));
            q.push_back(mk(d, 2'b11, base_of(d) + 32'h48, 1'b1, 3'd2, $urandom, 4'b0011));
            q.push_back(mk(d, 2'b11, base_of(d) + 32'h4C, 1'b1, 3'd2, wd4, 4'b0011));
            q.push_back(mk(d, 2'b10, base_of(d) + 32'h4C, 1'b0, 3'd2, 32'h0, 4'b0011));
            q.push_back(mk(d, 2'b10, base_of(d) + 32'h40, 1'b0, 3'd2, 32'h0, 4'b0011));
            q.push_back(mk(d, 2'b10, base_of(d) + 32'h48, 1'b0, 3'd2, 32'h0, 4'b0011));
            run();
        end

        drive_addr(mk(1, 2'b10, BASE1 + 32'h10, 1'b1, 3'd2, 32'h0, 4'b0011));
        @(posedge clk); #1;
        drive_idle();
        hwdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(negedge clk);
        hreset_n = 1'b0;
        #1;
        chk("abort_hready", {31'd0, hready1}, 32'd1);
        chk("abort_hresp", {30'd0, hresp1}, 32'd0);
        chk("abort_hrdata", hrdata1, 32'd0);
        @(negedge clk);
        hreset_n = 1'b1;
        @(posedge clk); #1;
        q.push_back(mk(1, 2'b10, BASE1 + 32'h10, 1'b0, 3'd2, 32'h0, 4'b0011));
        run();

`ifdef AHB_SLV_PROT_CHK_EN
        q.push_back(mk(0, 2'b10, 32'(MEM_DEPTH * 2), 1'b1, 3'd2, 32'h55AA_55AA, 4'b0001));
        q.push_back(mk(0, 2'b10, 32'(MEM_DEPTH * 2), 1'b0, 3'd2, 32'h0, 4'b0011));
        q.push_back(mk(0, 2'b10, 32'(MEM_DEPTH * 2), 1'b1, 3'd2, 32'h55AA_55AA, 4'b0011));
        q.push_back(mk(0, 2'b10, 32'(MEM_DEPTH * 2), 1'b0, 3'd2, 32'h0, 4'b0001));
        q.push_back(mk(0, 2'b10, 32'(MEM_DEPTH * 2), 1'b0, 3'd2, 32'h0, 4'b0011));
        q.push_back(mk(0, 2'b10, 32'h100, 1'b1, 3'd2, 32'h0F0F_0F0F, 4'b0001));
        run();
        chk("prot_rb", model_word(0, 32'(MEM_DEPTH * 2)), 32'h55AA_55AA);
        chk("prot_rd", last_rd, 32'h55AA_55AA);
`endif

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 80; k++) q.push_back(rnd_item(d));
            run();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb_slv_mem.md
Name: ahb_slv_mem

Overview:
- Parametrised AHB-Lite slave memory model. Serves as the synthesizable on-chip register/buffer target behind the encoder's AHB slave interface.
- Supports configurable data width, depth and wait states, byte-lane writes via hsize, and a two-cycle ERROR response for illegal accesses.
- Replaces fixed-width, zero-wait slave stubs. Sits between the AHB decoder/mux and the encoder's control/data storage.

Parameters:
- ADDR_WIDTH, 32: haddr width.
- DATA_WIDTH, 32: bus data width; legal values 32 or 64.
- MEM_DEPTH, 256: number of DATA_WIDTH-bit words.
- WAIT_STATES, 0: hready-low cycles inserted per OKAY data phase; range 0..15.
- BASE_ADDR, 32'h0: byte address of word 0.

Ports:
- clk  in  1  bus clock; all logic on posedge.
- hreset_n  in  1  asynchronous active-low reset.
- ahb_slv_hsel  in  1  slave select.
- ahb_slv_haddr  in  ADDR_WIDTH  byte address.
- ahb_slv_htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- ahb_slv_hwrite  in  1  1 = write, 0 = read.
- ahb_slv_hsize  in  3  transfer size (0 = byte, 1 = half, 2 = word, 3 = dword).
- ahb_slv_hburst  in  3  burst type; informational only.
- ahb_slv_hprot  in  4  protection control.
- ahb_slv_hwdata  in  DATA_WIDTH  write data.
- ahb_slv_hready  in  1  bus-level hready (previous transfer complete).
- slv_ahb_hrdata  out  DATA_WIDTH  read data.
- slv_ahb_hready  out  1  data-phase complete.
- slv_ahb_hresp  out  2  00 = OKAY, 01 = ERROR.

Behaviour:
- Reset: asynchronous assert on hreset_n low. Outputs: slv_ahb_hready=1, slv_ahb_hresp=00, slv_ahb_hrdata=0. FSM goes to IDLE, wait counter to 0. Storage is not reset.
- Reset asserted mid-transfer aborts the transfer; no partial write is committed.
- Address-phase accept: hsel & ahb_slv_hready & htrans[1].
  - On accept, register haddr, hwrite, hsize and the error flag.
  - On hsel with IDLE or BUSY, or with hsel low: next data phase is zero-wait OKAY with no access.
- Illegal access (error flag set) when any of:
  - haddr < BASE_ADDR, or haddr − BASE_ADDR >= MEM_DEPTH*DATA_WIDTH/8;
  - hsize > log2(DATA_WIDTH/8);
  - haddr not aligned to 2^hsize.
- FSM states:
  - IDLE: hready=1, resp=00. Accepted legal transfer → WAIT if WAIT_STATES>0, else DATA. Accepted illegal transfer → ERR1.
  - WAIT: hready=0, resp=00. Counter counts up; when it reaches WAIT_STATES−1 → DATA.
  - DATA: hready=1, resp=00. Read data valid; write committed on this edge. If a new transfer is accepted in the same cycle, the IDLE rules apply; otherwise → IDLE.
  - ERR1: hready=0, resp=01 → ERR2.
  - ERR2: hready=1, resp=01. No write, hrdata=0. Same next-state rules as DATA.
- Writes:
  - Byte lanes enabled = 2^hsize bytes starting at lane haddr[log2(DATA_WIDTH/8)−1:0], little-endian.
  - hwdata is sampled only on the edge where slv_ahb_hready=1 in DATA.
- Reads:
  - hrdata returns the full addressed word in DATA, 0 in all other states.
  - Read-after-write to the same word in the next transfer returns the newly written bytes; bypass is required.
- Bursts: SEQ is handled identically to NONSEQ. Address increment and wrap are the master's responsibility. BUSY inside a burst produces no access.
- Word index = (haddr − BASE_ADDR) >> log2(DATA_WIDTH/8), truncated to clog2(MEM_DEPTH) bits.

Optional Feature:
- Macro: AHB_SLV_PROT_CHK_EN.
- Defined: a user-mode access (hprot[1]=0) to the upper half of memory (word index >= MEM_DEPTH/2) is illegal → ERR1/ERR2 response, no write.
- Undefined: hprot is ignored; the port remains present but unused.

Test Plan:
- Reset with WAIT_STATES=0: hready=1, hresp=00, hrdata=0. Then write word 0x1234_5678 to BASE+0x4, read it back → hrdata=0x1234_5678, zero wait, OKAY.
- WAIT_STATES=3, single read → hready low exactly 3 cycles, then high with data; back-to-back NONSEQ reads each insert 3 waits.
- Byte write 0xAB to BASE+0x6 (hsize=0) over a word of 0xFFFF_FFFF → readback 0xFFAB_FFFF. Misaligned halfword at BASE+0x1 → ERROR, word unchanged.
- Address BASE+MEM_DEPTH*4 → hresp=01 with hready=0, then hresp=01 with hready=1. The next legal transfer returns OKAY.
- INCR4 write with a BUSY inserted after beat 2 → BUSY gives zero-wait OKAY with no write; all 4 beats land. Immediate read of the last address returns the new data (bypass).
- With AHB_SLV_PROT_CHK_EN: hprot=4'b0001 write to word MEM_DEPTH/2 → ERROR, no write; hprot=4'b0011 → OKAY, write lands.
